// File: rtl/xhci_mem_arbiter_pkg.sv
// Shared types for the xHCI DMA memory arbiter: engine state encodings, arbiter
// FSM states, the default watchdog limit and a round-robin pointer helper.
package xhci_mem_arbiter_pkg;

  typedef enum logic [3:0] {
    RD_IDLE  = 4'd0,
    RD_REQ   = 4'd1,
    RD_WAIT  = 4'd2,
    RD_DATA  = 4'd3,
    RD_DONE  = 4'd4
  } rd_state_t;

  typedef enum logic [3:0] {
    WR_IDLE      = 4'd0,
    WR_DATA_INIT = 4'd1,
    WR_DATA      = 4'd2,
    WR_COMPLETE  = 4'd3
  } wr_state_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam int ARB_TIMEOUT = 4096;
  localparam int HOLD_W      = 13;

  // Index following idx in a ring of n requesters.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/xhci_mem_arbiter_if.sv
// Requester-side and engine-side buses of the DMA memory arbiter.
// master = the arbiter itself, slave = the requesters plus the TLP engines.
interface xhci_mem_arbiter_if #(parameter int NUM_REQ = 4);

  logic [NUM_REQ-1:0][63:0]  rq_rd_addr;
  logic [NUM_REQ-1:0][31:0]  rq_rd_len;
  logic [NUM_REQ-1:0]        rq_rd_req;
  logic [NUM_REQ-1:0]        rq_rd_en;
  logic [NUM_REQ-1:0][3:0]   rq_rd_state;
  logic [127:0]              rq_rd_dout;

  logic [NUM_REQ-1:0][63:0]  rq_wr_addr;
  logic [NUM_REQ-1:0][31:0]  rq_wr_len;
  logic [NUM_REQ-1:0]        rq_wr_req;
  logic [NUM_REQ-1:0][127:0] rq_wr_din;
  logic [NUM_REQ-1:0]        rq_wr_en;
  logic [NUM_REQ-1:0]        rq_wr_done;
  logic [NUM_REQ-1:0][3:0]   rq_wr_state;

  logic [63:0]  eng_rd_addr;
  logic [31:0]  eng_rd_len;
  logic         eng_rd_req;
  logic         eng_rd_en;
  logic [3:0]   eng_rd_state;
  logic [127:0] eng_rd_dout;

  logic [63:0]  eng_wr_addr;
  logic [31:0]  eng_wr_len;
  logic         eng_wr_req;
  logic [127:0] eng_wr_din;
  logic         eng_wr_en;
  logic         eng_wr_done;
  logic [3:0]   eng_wr_state;

  modport master (
    input  rq_rd_addr, rq_rd_len, rq_rd_req, rq_rd_en,
    input  rq_wr_addr, rq_wr_len, rq_wr_req, rq_wr_din, rq_wr_en, rq_wr_done,
    input  eng_rd_state, eng_rd_dout, eng_wr_state,
    output rq_rd_state, rq_rd_dout, rq_wr_state,
    output eng_rd_addr, eng_rd_len, eng_rd_req, eng_rd_en,
    output eng_wr_addr, eng_wr_len, eng_wr_req, eng_wr_din, eng_wr_en, eng_wr_done
  );

  modport slave (
    output rq_rd_addr, rq_rd_len, rq_rd_req, rq_rd_en,
    output rq_wr_addr, rq_wr_len, rq_wr_req, rq_wr_din, rq_wr_en, rq_wr_done,
    output eng_rd_state, eng_rd_dout, eng_wr_state,
    input  rq_rd_state, rq_rd_dout, rq_wr_state,
    input  eng_rd_addr, eng_rd_len, eng_rd_req, eng_rd_en,
    input  eng_wr_addr, eng_wr_len, eng_wr_req, eng_wr_din, eng_wr_en, eng_wr_done
  );

endinterface

// File: rtl/xhci_mem_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted req at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_vld
);

  logic [N-1:0][IW-1:0] cand_idx;
  logic [N-1:0]         cand_hit;

  // Candidate gi is the requester sitting gi places after ptr.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cand
      logic [IW:0] sum;
      assign sum          = {1'b0, ptr} + (IW+1)'(gi);
      assign cand_idx[gi] = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
      assign cand_hit[gi] = req[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    gnt_vld = |req;
    gnt_idx = ptr;
    for (int k = N - 1; k >= 0; k--) begin
      if (cand_hit[k]) gnt_idx = cand_idx[k];
    end
  end

endmodule

// File: rtl/xhci_mem_arbiter.sv
// Round-robin lock arbiter sharing one DMA read engine and one write engine among
// NUM_REQ xHCI requesters; the owner holds both channels until it goes quiet.
module xhci_mem_arbiter
  import xhci_mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = ARB_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  xhci_mem_arbiter_if.master  bus,
  output logic [2:0]          owner,
  output logic                owner_vld,
  output logic                timeout_err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(TIMEOUT_CYC - 1);

  arb_state_t         state_reg, state_next;
  logic [IDX_W-1:0]   owner_reg, owner_next;
  logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic               owner_vld_reg, owner_vld_next;
  logic               timeout_err_reg, timeout_err_next;
  logic [HOLD_W-1:0]  hold_cnt_reg, hold_cnt_next;
  logic [NUM_REQ-1:0] stuck_mask_reg, stuck_mask_next;

  logic [NUM_REQ-1:0] active, arb_req;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_vld;
  logic               engines_idle;

  assign active       = bus.rq_rd_req | bus.rq_wr_req;
  assign arb_req      = active & ~stuck_mask_reg;
  assign engines_idle = (bus.eng_rd_state == RD_IDLE) && (bus.eng_wr_state == WR_IDLE);

  rr_arbiter #(.N(NUM_REQ), .IW(IDX_W)) u_rr (
    .req     (arb_req),
    .ptr     (rr_ptr_reg),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      owner_reg       <= '0;
      rr_ptr_reg      <= '0;
      owner_vld_reg   <= 1'b0;
      timeout_err_reg <= 1'b0;
      hold_cnt_reg    <= '0;
      stuck_mask_reg  <= '0;
    end else begin
      state_reg       <= state_next;
      owner_reg       <= owner_next;
      rr_ptr_reg      <= rr_ptr_next;
      owner_vld_reg   <= owner_vld_next;
      timeout_err_reg <= timeout_err_next;
      hold_cnt_reg    <= hold_cnt_next;
      stuck_mask_reg  <= stuck_mask_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    owner_next       = owner_reg;
    rr_ptr_next      = rr_ptr_reg;
    owner_vld_next   = owner_vld_reg;
    timeout_err_next = 1'b0;
    hold_cnt_next    = hold_cnt_reg;
    // A timed-out requester stays excluded until it drops its request once.
    stuck_mask_next  = stuck_mask_reg & active;

    case (state_reg)
      IDLE: begin
        if (gnt_vld) begin
          owner_next     = gnt_idx;
          owner_vld_next = 1'b1;
          hold_cnt_next  = '0;
          state_next     = GRANT;
        end
      end
      GRANT: begin
        hold_cnt_next = hold_cnt_reg + 1'b1;
        if (!active[owner_reg]) begin
          state_next = RELEASE;
        end else if (hold_cnt_reg == HOLD_LIMIT) begin
          state_next                 = RELEASE;
          timeout_err_next           = 1'b1;
          stuck_mask_next[owner_reg] = 1'b1;
        end
      end
      RELEASE: begin
        if (engines_idle) begin
          rr_ptr_next    = IDX_W'(rr_next(int'(owner_reg), NUM_REQ));
          owner_vld_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Engine side sees only the owner, and only while the grant is live.
  always_comb begin
    bus.eng_rd_addr = '0;
    bus.eng_rd_len  = '0;
    bus.eng_rd_req  = 1'b0;
    bus.eng_rd_en   = 1'b0;
    bus.eng_wr_addr = '0;
    bus.eng_wr_len  = '0;
    bus.eng_wr_req  = 1'b0;
    bus.eng_wr_din  = '0;
    bus.eng_wr_en   = 1'b0;
    bus.eng_wr_done = 1'b0;
    if (state_reg == GRANT) begin
      bus.eng_rd_addr = bus.rq_rd_addr[owner_reg];
      bus.eng_rd_len  = bus.rq_rd_len[owner_reg];
      bus.eng_rd_req  = bus.rq_rd_req[owner_reg];
      bus.eng_rd_en   = bus.rq_rd_en[owner_reg];
      bus.eng_wr_addr = bus.rq_wr_addr[owner_reg];
      bus.eng_wr_len  = bus.rq_wr_len[owner_reg];
      bus.eng_wr_req  = bus.rq_wr_req[owner_reg];
      bus.eng_wr_din  = bus.rq_wr_din[owner_reg];
      bus.eng_wr_en   = bus.rq_wr_en[owner_reg];
      bus.eng_wr_done = bus.rq_wr_done[owner_reg];
    end
  end

  logic [NUM_REQ-1:0][3:0] rd_state_vec, wr_state_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_state
      logic is_owner;
      assign is_owner         = owner_vld_reg && (owner_reg == IDX_W'(gi));
      assign rd_state_vec[gi] = is_owner ? bus.eng_rd_state : 4'(RD_IDLE);
      assign wr_state_vec[gi] = is_owner ? bus.eng_wr_state : 4'(WR_IDLE);
    end
  endgenerate

  assign bus.rq_rd_state = rd_state_vec;
  assign bus.rq_wr_state = wr_state_vec;
  assign bus.rq_rd_dout  = bus.eng_rd_dout;

  assign owner       = 3'(owner_reg);
  assign owner_vld   = owner_vld_reg;
  assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_xhci_mem_arbiter.sv
// Bench for xhci_mem_arbiter: directed scenarios plus a randomized run checked
// against a round-robin grant model driven by the bench's own request vectors.
module tb_xhci_mem_arbiter;
  import xhci_mem_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int TO = 40;

  logic clk = 1'b0;
  logic rst;
  logic [2:0] owner;
  logic owner_vld, timeout_err;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  xhci_mem_arbiter_if #(.NUM_REQ(N)) bus();

  xhci_mem_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .owner(owner), .owner_vld(owner_vld), .timeout_err(timeout_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.rq_rd_addr = '0; bus.rq_rd_len = '0; bus.rq_rd_req = '0; bus.rq_rd_en = '0;
    bus.rq_wr_addr = '0; bus.rq_wr_len = '0; bus.rq_wr_req = '0; bus.rq_wr_din = '0;
    bus.rq_wr_en = '0; bus.rq_wr_done = '0;
    bus.eng_rd_state = RD_IDLE; bus.eng_wr_state = WR_IDLE; bus.eng_rd_dout = '0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // Bounded wait for owner_vld to reach lvl; ok=0 if the budget runs out.
  task automatic wait_vld(input logic lvl, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (owner_vld === lvl) begin ok = 1'b1; return; end
      tick();
    end
    if (owner_vld === lvl) ok = 1'b1;
  endtask

  // Reference rule: first active index at or after ptr, wrapping.
  function automatic int rr_pick(input logic [N-1:0] act, input int ptr);
    for (int k = 0; k < N; k++) if (act[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    bus.rq_rd_req = '1; bus.rq_wr_req = '1; bus.rq_rd_addr[0] = 64'h55;
    bus.eng_rd_state = RD_DATA; bus.eng_wr_state = WR_DATA;
    repeat (3) tick();
    n_cmp++; if (owner_vld !== 1'b0) begin n_bad++; $display("FAIL reset_owner_vld: got %0h want 0", owner_vld); end
    n_cmp++; if (owner !== 3'd0) begin n_bad++; $display("FAIL reset_owner: got %0h want 0", owner); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL reset_timeout_err: got %0h want 0", timeout_err); end
    n_cmp++; if ({bus.eng_rd_req, bus.eng_wr_req, bus.eng_rd_addr} !== '0) begin n_bad++; $display("FAIL reset_eng: got %0h want 0", {bus.eng_rd_req, bus.eng_wr_req, bus.eng_rd_addr}); end
    n_cmp++; if ({bus.rq_rd_state, bus.rq_wr_state} !== '0) begin n_bad++; $display("FAIL reset_rq_state: got %0h want 0", {bus.rq_rd_state, bus.rq_wr_state}); end
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_single();
    bit ok;
    apply_reset();
    bus.rq_rd_addr[1] = 64'h1000; bus.rq_rd_len[1] = 32'h20; bus.rq_rd_req[1] = 1'b1;
    #1;
    n_cmp++; if (owner_vld !== 1'b0) begin n_bad++; $display("FAIL single_early: got %0h want 0", owner_vld); end
    tick();
    n_cmp++; if ({owner_vld, owner} !== {1'b1, 3'd1}) begin n_bad++; $display("FAIL single_grant: got %0h want 9", {owner_vld, owner}); end
    n_cmp++; if (bus.eng_rd_addr !== 64'h1000 || bus.eng_rd_len !== 32'h20 || bus.eng_rd_req !== 1'b1) begin n_bad++; $display("FAIL single_mux: got %0h/%0h/%0h want 1000/20/1", bus.eng_rd_addr, bus.eng_rd_len, bus.eng_rd_req); end
    bus.eng_rd_state = RD_DATA;
    #1;
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (bus.rq_rd_state[i] !== ((i == 1) ? 4'(RD_DATA) : 4'(RD_IDLE))) begin n_bad++; $display("FAIL single_rd_state[%0d]: got %0h want %0h", i, bus.rq_rd_state[i], (i == 1) ? 4'(RD_DATA) : 4'(RD_IDLE)); end
    end
    bus.rq_rd_req[1] = 1'b0; bus.eng_rd_state = RD_IDLE;
    wait_vld(1'b0, 10, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_release: got timeout want owner_vld 0"); end
  endtask

  task automatic test_contention();
    bit ok;
    int exp_order[3] = '{0, 2, 3};
    apply_reset();
    for (int i = 0; i < N; i++) bus.rq_rd_addr[i] = 64'h100 * (i + 1);
    bus.rq_rd_req = 4'b1101;
    for (int k = 0; k < 3; k++) begin
      wait_vld(1'b1, 20, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL contention_wait%0d: got timeout want grant", k); end
      n_cmp++; if (owner !== 3'(exp_order[k])) begin n_bad++; $display("FAIL contention_order%0d: got %0d want %0d", k, owner, exp_order[k]); end
      n_cmp++; if (bus.eng_rd_addr !== 64'h100 * (exp_order[k] + 1)) begin n_bad++; $display("FAIL contention_addr%0d: got %0h want %0h", k, bus.eng_rd_addr, 64'h100 * (exp_order[k] + 1)); end
      repeat (2) tick();
      bus.rq_rd_req[exp_order[k]] = 1'b0;
      wait_vld(1'b0, 20, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL contention_gap%0d: got no idle gap want owner_vld 0", k); end
    end
  endtask

  task automatic test_rmw();
    bit ok;
    apply_reset();
    bus.rq_wr_addr[0] = 64'h2000; bus.rq_wr_req[0] = 1'b1;
    tick();
    n_cmp++; if ({owner_vld, owner} !== {1'b1, 3'd0}) begin n_bad++; $display("FAIL rmw_grant: got %0h want 8", {owner_vld, owner}); end
    bus.eng_wr_state = WR_DATA_INIT; bus.rq_rd_req[1] = 1'b1;
    #1;
    n_cmp++; if (bus.rq_wr_state[0] !== 4'(WR_DATA_INIT) || bus.rq_wr_state[1] !== 4'(WR_IDLE)) begin n_bad++; $display("FAIL rmw_wr_state: got %0h/%0h want 1/0", bus.rq_wr_state[0], bus.rq_wr_state[1]); end
    bus.rq_rd_addr[0] = 64'h3000; bus.rq_rd_req[0] = 1'b1; bus.eng_rd_state = RD_DATA;
    repeat (3) begin
      tick();
      n_cmp++; if ({owner_vld, owner} !== {1'b1, 3'd0}) begin n_bad++; $display("FAIL rmw_hold: got %0h want 8", {owner_vld, owner}); end
    end
    n_cmp++; if (bus.eng_rd_addr !== 64'h3000 || bus.eng_wr_req !== 1'b1) begin n_bad++; $display("FAIL rmw_both: got %0h/%0h want 3000/1", bus.eng_rd_addr, bus.eng_wr_req); end
    bus.eng_wr_state = WR_COMPLETE; bus.rq_wr_req[0] = 1'b0;
    tick();
    n_cmp++; if ({owner_vld, owner, bus.eng_wr_req, bus.eng_rd_req} !== 6'b1_000_01) begin n_bad++; $display("FAIL rmw_wr_drop: got %0b want 100001", {owner_vld, owner, bus.eng_wr_req, bus.eng_rd_req}); end
    n_cmp++; if (bus.rq_wr_state[0] !== 4'(WR_COMPLETE)) begin n_bad++; $display("FAIL rmw_complete: got %0h want 3", bus.rq_wr_state[0]); end
    bus.rq_rd_req[0] = 1'b0;
    repeat (3) begin
      tick();
      n_cmp++; if ({owner_vld, owner, bus.eng_rd_req} !== 5'b1_000_0) begin n_bad++; $display("FAIL rmw_wait_idle: got %0b want 10000", {owner_vld, owner, bus.eng_rd_req}); end
    end
    bus.eng_rd_state = RD_IDLE; bus.eng_wr_state = WR_IDLE;
    wait_vld(1'b0, 10, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rmw_release: got timeout want owner_vld 0"); end
    wait_vld(1'b1, 10, ok);
    n_cmp++; if (!ok || owner !== 3'd1) begin n_bad++; $display("FAIL rmw_next: got ok=%0d owner=%0d want ok=1 owner=1", ok, owner); end
    bus.rq_rd_req[1] = 1'b0;
    wait_vld(1'b0, 10, ok);
  endtask

  task automatic test_isolation();
    bit ok;
    apply_reset();
    bus.rq_wr_req[0] = 1'b1; bus.rq_wr_din[0] = 128'h1234; bus.rq_wr_addr[0] = 64'h4000;
    tick();
    bus.rq_wr_en[2] = 1'b1; bus.rq_wr_din[2] = 128'hDEAD; bus.rq_wr_done[2] = 1'b1; bus.rq_rd_en[2] = 1'b1;
    #1;
    n_cmp++; if ({bus.eng_wr_en, bus.eng_wr_done, bus.eng_rd_en} !== 3'b000) begin n_bad++; $display("FAIL iso_strobes: got %0b want 000", {bus.eng_wr_en, bus.eng_wr_done, bus.eng_rd_en}); end
    n_cmp++; if (bus.eng_wr_din !== 128'h1234) begin n_bad++; $display("FAIL iso_din: got %0h want 1234", bus.eng_wr_din); end
    bus.rq_wr_en[0] = 1'b1;
    #1;
    n_cmp++; if (bus.eng_wr_en !== 1'b1) begin n_bad++; $display("FAIL iso_owner_en: got %0h want 1", bus.eng_wr_en); end
    clear_inputs();
    wait_vld(1'b0, 10, ok);
  endtask

  task automatic test_timeout();
    bit ok, seen, any_vld;
    int cnt;
    apply_reset();
    bus.rq_rd_req[3] = 1'b1;
    tick();
    n_cmp++; if ({owner_vld, owner} !== {1'b1, 3'd3}) begin n_bad++; $display("FAIL to_grant: got %0h want b", {owner_vld, owner}); end
    bus.rq_rd_req[0] = 1'b1;
    cnt = 0; seen = 1'b0;
    for (int c = 0; c < TO + 10; c++) begin
      if (timeout_err === 1'b1) begin seen = 1'b1; break; end
      if (bus.eng_rd_req === 1'b1) cnt++;
      tick();
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL to_pulse: got none want timeout_err"); end
    n_cmp++; if (cnt != TO) begin n_bad++; $display("FAIL to_hold_cycles: got %0d want %0d", cnt, TO); end
    n_cmp++; if (bus.eng_rd_req !== 1'b0) begin n_bad++; $display("FAIL to_eng_drop: got %0h want 0", bus.eng_rd_req); end
    tick();
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL to_one_shot: got %0h want 0", timeout_err); end
    wait_vld(1'b1, 10, ok);
    n_cmp++; if (!ok || owner !== 3'd0) begin n_bad++; $display("FAIL to_pending: got ok=%0d owner=%0d want ok=1 owner=0", ok, owner); end
    bus.rq_rd_req[0] = 1'b0;
    wait_vld(1'b0, 10, ok);
    any_vld = 1'b0;
    repeat (6) begin tick(); if (owner_vld !== 1'b0) any_vld = 1'b1; end
    n_cmp++; if (any_vld) begin n_bad++; $display("FAIL to_stuck_masked: got regrant want none"); end
    bus.rq_rd_req[3] = 1'b0;
    tick();
    bus.rq_rd_req[3] = 1'b1;
    wait_vld(1'b1, 10, ok);
    n_cmp++; if (!ok || owner !== 3'd3) begin n_bad++; $display("FAIL to_unmask: got ok=%0d owner=%0d want ok=1 owner=3", ok, owner); end
    clear_inputs();
    wait_vld(1'b0, 10, ok);
  endtask

  task automatic test_reset_mid_grant();
    bit ok;
    apply_reset();
    bus.rq_rd_req[2] = 1'b1;
    wait_vld(1'b1, 10, ok);
    bus.rq_rd_req[2] = 1'b0;
    wait_vld(1'b0, 10, ok);
    bus.rq_rd_req[3] = 1'b1; bus.rq_wr_req[3] = 1'b1;
    bus.rq_rd_addr[3] = 64'h7000; bus.rq_wr_din[3] = 128'hBEEF;
    wait_vld(1'b1, 10, ok);
    n_cmp++; if (!ok || owner !== 3'd3 || bus.eng_wr_req !== 1'b1) begin n_bad++; $display("FAIL rmid_grant: got owner=%0d wr=%0h want 3/1", owner, bus.eng_wr_req); end
    rst = 1'b1;
    tick();
    n_cmp++; if (owner_vld !== 1'b0) begin n_bad++; $display("FAIL rmid_vld: got %0h want 0", owner_vld); end
    n_cmp++; if ({bus.eng_rd_req, bus.eng_wr_req, bus.eng_rd_addr, bus.eng_wr_din} !== '0) begin n_bad++; $display("FAIL rmid_eng: got %0h want 0", {bus.eng_rd_req, bus.eng_wr_req, bus.eng_rd_addr, bus.eng_wr_din}); end
    rst = 1'b0;
    bus.rq_rd_req[1] = 1'b1;
    tick();
    n_cmp++; if ({owner_vld, owner} !== {1'b1, 3'd1}) begin n_bad++; $display("FAIL rmid_ptr: got %0h want 9", {owner_vld, owner}); end
    clear_inputs();
    wait_vld(1'b0, 10, ok);
  endtask

  task automatic test_random();
    logic [N-1:0] act;
    logic [N-1:0][3:0] exp_rs, exp_ws;
    int ptr_m, hold[N], exp_o, o;
    bit prev_vld, in_g;
    apply_reset();
    ptr_m = 0; prev_vld = 1'b0;
    for (int i = 0; i < N; i++) hold[i] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      act = bus.rq_rd_req | bus.rq_wr_req;
      if (!prev_vld) begin
        n_cmp++; if (owner_vld !== (|act)) begin n_bad++; $display("FAIL rnd_vld c%0d: got %0h want %0h", cyc, owner_vld, |act); end
        if (owner_vld === 1'b1) begin
          exp_o = rr_pick(act, ptr_m);
          n_cmp++; if (owner !== 3'(exp_o)) begin n_bad++; $display("FAIL rnd_owner c%0d: got %0d want %0d", cyc, owner, exp_o); end
          ptr_m = (exp_o + 1) % N;
          hold[owner % N] = $urandom_range(1, 6);
        end
      end
      o = owner % N;
      in_g = (owner_vld === 1'b1) && act[o];
      n_cmp++;
      if ({bus.eng_rd_addr, bus.eng_rd_len, bus.eng_rd_req, bus.eng_rd_en, bus.eng_wr_addr, bus.eng_wr_len}
          !== (in_g ? {bus.rq_rd_addr[o], bus.rq_rd_len[o], bus.rq_rd_req[o], bus.rq_rd_en[o], bus.rq_wr_addr[o], bus.rq_wr_len[o]} : 194'd0)) begin
        n_bad++; $display("FAIL rnd_rd_mux c%0d: got %0h/%0h want owner %0d in_grant %0d", cyc, bus.eng_rd_addr, bus.eng_rd_req, o, in_g);
      end
      n_cmp++;
      if ({bus.eng_wr_req, bus.eng_wr_din, bus.eng_wr_en, bus.eng_wr_done}
          !== (in_g ? {bus.rq_wr_req[o], bus.rq_wr_din[o], bus.rq_wr_en[o], bus.rq_wr_done[o]} : 131'd0)) begin
        n_bad++; $display("FAIL rnd_wr_mux c%0d: got %0h/%0h want owner %0d in_grant %0d", cyc, bus.eng_wr_din, bus.eng_wr_req, o, in_g);
      end
      for (int i = 0; i < N; i++) begin
        exp_rs[i] = (owner_vld === 1'b1 && o == i) ? bus.eng_rd_state : 4'(RD_IDLE);
        exp_ws[i] = (owner_vld === 1'b1 && o == i) ? bus.eng_wr_state : 4'(WR_IDLE);
      end
      n_cmp++; if ({bus.rq_rd_state, bus.rq_wr_state} !== {exp_rs, exp_ws}) begin n_bad++; $display("FAIL rnd_states c%0d: got %0h want %0h", cyc, {bus.rq_rd_state, bus.rq_wr_state}, {exp_rs, exp_ws}); end
      n_cmp++; if (bus.rq_rd_dout !== bus.eng_rd_dout || timeout_err !== 1'b0) begin n_bad++; $display("FAIL rnd_dout_to c%0d: got %0h/%0h want %0h/0", cyc, bus.rq_rd_dout, timeout_err, bus.eng_rd_dout); end
      prev_vld = (owner_vld === 1'b1);
      for (int i = 0; i < N; i++) begin
        if (owner_vld === 1'b1 && o == i && act[i]) begin
          hold[i]--;
          if (hold[i] <= 0) begin bus.rq_rd_req[i] = 1'b0; bus.rq_wr_req[i] = 1'b0; end
        end else if (!act[i] && !(owner_vld === 1'b1 && o == i) && ($urandom % 5 == 0)) begin
          bus.rq_rd_req[i] = 1'($urandom);
          bus.rq_wr_req[i] = bus.rq_rd_req[i] ? 1'($urandom) : 1'b1;
          bus.rq_rd_addr[i] = {$urandom, $urandom}; bus.rq_wr_addr[i] = {$urandom, $urandom};
          bus.rq_rd_len[i] = $urandom; bus.rq_wr_len[i] = $urandom;
        end
        bus.rq_wr_din[i] = {$urandom, $urandom, $urandom, $urandom};
      end
      bus.rq_rd_en = 4'($urandom); bus.rq_wr_en = 4'($urandom); bus.rq_wr_done = 4'($urandom);
      bus.eng_rd_dout = {$urandom, $urandom, $urandom, $urandom};
      bus.eng_rd_state = (owner_vld === 1'b1 && $urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 4)) : 4'(RD_IDLE);
      bus.eng_wr_state = (owner_vld === 1'b1 && $urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 3)) : 4'(WR_IDLE);
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single();
    test_contention();
    test_rmw();
    test_isolation();
    test_timeout();
    test_reset_mid_grant();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish before 1ms");
    $fatal(1);
  end

endmodule
